// File: rtl/piso_pkg.sv
// Shared types and width helpers for the piso input arbiter.
package piso_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  // BEAT_W and PTR_W depend on module parameters, so they are provided as constant functions
  function automatic int beat_w(input int burst_max);
    return $clog2(burst_max + 1);
  endfunction

  function automatic int ptr_w(input int n_req);
    return $clog2(n_req);
  endfunction

endpackage

// File: rtl/piso_rr_pick.sv
// Combinational round-robin picker: rotate by rr_ptr, take lowest set bit, rotate back.
module piso_rr_pick
  import piso_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req_valid_i,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] win,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  int               src;
  int               first;

  // Explicit wrap keeps the rotation correct when N_REQ is not a power of two
  always_comb begin
    rot   = '0;
    win   = '0;
    first = -1;
    src   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      src = i + int'(rr_ptr);
      if (src >= N_REQ) src = src - N_REQ;
      for (int j = 0; j < N_REQ; j++) begin
        if (j == src) rot[i] = req_valid_i[j];
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) first = i;
    end
    if (first >= 0) begin
      src = first + int'(rr_ptr);
      if (src >= N_REQ) src = src - N_REQ;
      for (int j = 0; j < N_REQ; j++) begin
        if (j == src) win[j] = 1'b1;
      end
    end
  end

  assign any = |req_valid_i;

endmodule

// File: rtl/piso_arbiter.sv
// Round-robin burst arbiter in front of the piso parallel input.
// Define PISO_ARB_PRIO_EN to give requester 0 absolute priority at grant time.
module piso_arbiter
  import piso_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int BURST_MAX = 16
) (
  input  logic                   clk_p,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  input  logic [N_REQ*WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]       req_ready_o,
  output logic [WIDTH-1:0]       piso_d_o,
  output logic                   piso_valid_o,
  input  logic                   piso_ready_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic                   busy_o
);

  localparam int BEAT_W = beat_w(BURST_MAX);
  localparam int PTR_W  = ptr_w(N_REQ);

  state_e            state;
  logic [N_REQ-1:0]  grant;
  logic [PTR_W-1:0]  owner;
  logic [PTR_W-1:0]  rr_ptr;
  logic [BEAT_W-1:0] beat_cnt;

  logic [N_REQ-1:0]  rr_win;
  logic [N_REQ-1:0]  win;
  logic [PTR_W-1:0]  win_idx;
  logic              any;
  logic              own_valid;
  logic              beat;
  logic              last_beat;
  logic              release_now;

  piso_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_valid_i (req_valid_i),
    .rr_ptr      (rr_ptr),
    .win         (rr_win),
    .any         (any)
  );

`ifdef PISO_ARB_PRIO_EN
  assign win = req_valid_i[0] ? N_REQ'(1) : rr_win;
`else
  assign win = rr_win;
`endif

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) win_idx = PTR_W'(i);
    end
  end

  // Output mux is driven straight from the registered one-hot grant
  always_comb begin
    piso_d_o    = '0;
    own_valid   = 1'b0;
    req_ready_o = '0;
    if (state == ST_OWN) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i]) begin
          piso_d_o       = req_data_i[i*WIDTH +: WIDTH];
          own_valid      = req_valid_i[i];
          req_ready_o[i] = piso_ready_i;
        end
      end
    end
  end

  assign piso_valid_o = own_valid;
  assign beat         = own_valid & piso_ready_i;
  assign last_beat    = beat && (beat_cnt == BEAT_W'(BURST_MAX - 1));
  assign release_now  = (state == ST_OWN) && (!own_valid || last_beat);
  assign grant_o      = grant;
  assign busy_o       = (state == ST_OWN);

  always_ff @(posedge clk_p) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      grant    <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            state    <= ST_OWN;
            grant    <= win;
            owner    <= win_idx;
            beat_cnt <= '0;
          end
        end
        ST_OWN: begin
          if (release_now) begin
            state  <= ST_IDLE;
            grant  <= '0;
            rr_ptr <= (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + PTR_W'(1);
          end else if (beat) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
